// File: rtl/i2s_sound_tester.sv
// I2S test-tone source: derives bit/word clocks from a 256*fs input clock and
// serialises a square-wave tone as Philips I2S frames, plus probe copies and heartbeat LEDs.
module i2s_sound_tester #(
  parameter logic signed [15:0] SAMPLE_HI           = 16'sh2000,
  parameter logic signed [15:0] SAMPLE_LO           = 16'shE000,
  parameter int                 HALF_PERIOD_SAMPLES = 24,
  parameter int                 LED_HALF_FRAMES     = 24000
) (
  input  logic       input_clk,
  input  logic       reset,
  output logic       serial_clk,
  output logic       dac_mclk,
  output logic       word_select,
  output logic       sound_bit_out,
  output logic       serial_clk_analyzer,
  output logic       input_clk_analyzer,
  output logic       test_LED,
  output logic       test_LED_R,
  output logic       test_LED_G,
  output logic       test_LED_B,
  output logic [5:0] bit_counter
);

  localparam int IDX_MAX = 2 * HALF_PERIOD_SAMPLES - 1;
  localparam int IW      = (IDX_MAX > 0) ? $clog2(IDX_MAX + 1) : 1;
  localparam int FW      = (LED_HALF_FRAMES > 1) ? $clog2(LED_HALF_FRAMES) : 1;

  logic [1:0]    div_q, div_d;
  logic [5:0]    bit_q, bit_d;
  logic          ws_q, ws_d;
  logic          sd_q, sd_d;
  logic [15:0]   sample_q, sample_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          led_q, led_d;
  logic [2:0]    rgb_q, rgb_d;

  logic          sce;
  logic [5:0]    bit_inc;
  logic [4:0]    pos;

  always_comb begin
    sce      = (div_q == 2'd3);
    bit_inc  = bit_q + 6'd1;
    // Data trails word_select by one slot, so slot 1 carries the MSB.
    pos      = bit_inc[4:0] - 5'd1;
    div_d    = div_q + 2'd1;
    bit_d    = bit_q;
    ws_d     = ws_q;
    sd_d     = sd_q;
    sample_d = sample_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    led_d    = led_q;
    rgb_d    = rgb_q;
    if (sce) begin
      bit_d = bit_inc;
      ws_d  = bit_inc[5];
      sd_d  = pos[4] ? 1'b0 : sample_q[4'd15 - pos[3:0]];
      if (bit_inc == 6'd0) begin
        idx_d    = (idx_q == IW'(IDX_MAX)) ? '0 : idx_q + IW'(1);
        sample_d = (idx_d < IW'(HALF_PERIOD_SAMPLES)) ? SAMPLE_HI : SAMPLE_LO;
        if (frame_q == FW'(LED_HALF_FRAMES - 1)) begin
          frame_d = '0;
          led_d   = ~led_q;
          if (!led_q) begin
            rgb_d = rgb_q + 3'd1;
          end
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      bit_q    <= '0;
      ws_q     <= 1'b0;
      sd_q     <= 1'b0;
      sample_q <= SAMPLE_HI;
      idx_q    <= '0;
      frame_q  <= '0;
      led_q    <= 1'b0;
      rgb_q    <= '0;
    end else begin
      div_q    <= div_d;
      bit_q    <= bit_d;
      ws_q     <= ws_d;
      sd_q     <= sd_d;
      sample_q <= sample_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      led_q    <= led_d;
      rgb_q    <= rgb_d;
    end
  end

  assign serial_clk          = div_q[1];
  assign serial_clk_analyzer = div_q[1];
  assign dac_mclk            = input_clk;
  assign input_clk_analyzer  = input_clk;
  assign word_select         = ws_q;
  assign sound_bit_out       = sd_q;
  assign bit_counter         = bit_q;
  assign test_LED            = led_q;
  assign test_LED_R          = rgb_q[2];
  assign test_LED_G          = rgb_q[1];
  assign test_LED_B          = rgb_q[0];

endmodule

// File: tb/tb_i2s_sound_tester.sv
// Scoreboard bench for i2s_sound_tester: expected slots are queued per frame and
// compared at every serial_clk rising edge, where the DAC would sample.
module tb_i2s_sound_tester;

  localparam int          HALF = 24;
  localparam int          LEDH = 4;
  localparam logic [15:0] HI   = 16'h2000;
  localparam logic [15:0] LO   = 16'hE000;

  logic       input_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       serial_clk, dac_mclk, word_select, sound_bit_out;
  logic       serial_clk_analyzer, input_clk_analyzer;
  logic       test_LED, test_LED_R, test_LED_G, test_LED_B;
  logic [5:0] bit_counter;

  i2s_sound_tester #(
    .SAMPLE_HI(16'sh2000),
    .SAMPLE_LO(16'shE000),
    .HALF_PERIOD_SAMPLES(HALF),
    .LED_HALF_FRAMES(LEDH)
  ) dut (
    .input_clk(input_clk),
    .reset(reset),
    .serial_clk(serial_clk),
    .dac_mclk(dac_mclk),
    .word_select(word_select),
    .sound_bit_out(sound_bit_out),
    .serial_clk_analyzer(serial_clk_analyzer),
    .input_clk_analyzer(input_clk_analyzer),
    .test_LED(test_LED),
    .test_LED_R(test_LED_R),
    .test_LED_G(test_LED_G),
    .test_LED_B(test_LED_B),
    .bit_counter(bit_counter)
  );

  always #5 input_clk = ~input_clk;

  typedef struct packed {
    logic [5:0] slot;
    logic       ws;
    logic       sd;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   first_rise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Returns the number of input_clk cycles until the next serial_clk rise, -1 on timeout.
  task automatic wait_rise(output int n);
    logic prev;
    n    = 0;
    prev = serial_clk;
    while (n < 16) begin
      @(negedge input_clk);
      n++;
      if (serial_clk === 1'b1 && prev === 1'b0) return;
      prev = serial_clk;
    end
    n = -1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sclk"}, 32'(serial_clk), 32'd0);
    check({tag, "_ws"},   32'(word_select), 32'd0);
    check({tag, "_sd"},   32'(sound_bit_out), 32'd0);
    check({tag, "_bc"},   32'(bit_counter), 32'd0);
    check({tag, "_led"},  32'({test_LED, test_LED_R, test_LED_G, test_LED_B}), 32'd0);
  endtask

  // f = frames completed since reset release; stops after sampling last_slot.
  task automatic run_frame(input int f, input int last_slot);
    logic [15:0] s;
    exp_t        e;
    int          n;
    int          p;
    int          t;
    s = ((f % 48) < HALF) ? HI : LO;
    for (int k = 0; k < 64; k++) begin
      p      = (k + 31) % 32;
      e.slot = 6'(k);
      e.ws   = (k >= 32);
      e.sd   = (p < 16) ? s[15 - p] : 1'b0;
      sb_q.push_back(e);
    end
    for (int k = 0; k <= last_slot; k++) begin
      wait_rise(n);
      check("period", 32'(n), first_rise ? 32'd2 : 32'd4);
      first_rise = 1'b0;
      check("sclk_an", 32'(serial_clk_analyzer), 32'd1);
      e = sb_q.pop_front();
      check("slot", 32'(bit_counter), 32'(e.slot));
      check("ws",   32'(word_select), 32'(e.ws));
      check("data", 32'(sound_bit_out), 32'(e.sd));
      if (k == 0) begin
        t = f / LEDH;
        check("led", 32'(test_LED), 32'(t % 2));
        check("rgb", 32'({test_LED_R, test_LED_G, test_LED_B}), 32'(((t + 1) / 2) % 8));
      end
    end
    $display("frame %0d sample=%h slots=%0d errors_so_far=%0d", f, s, last_slot + 1, bad);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge input_clk);
    check_idle("rst");
    check("mclk_lo", 32'(dac_mclk), 32'd0);
    check("iclk_an_lo", 32'(input_clk_analyzer), 32'd0);
    @(posedge input_clk);
    #1;
    check("mclk_hi", 32'(dac_mclk), 32'd1);
    check("iclk_an_hi", 32'(input_clk_analyzer), 32'd1);
    @(negedge input_clk);
    reset      = 1'b0;
    first_rise = 1'b1;

    // Covers the full tone period, its return to SAMPLE_HI and several LED toggles.
    for (int f = 0; f < 50; f++) run_frame(f, 63);

    run_frame(50, 40);
    reset = 1'b1;
    #1;
    check_idle("midrst");
    repeat (3) @(negedge input_clk);
    check_idle("midrst_hold");
    reset = 1'b0;
    sb_q.delete();
    first_rise = 1'b1;
    for (int f = 0; f < 2; f++) run_frame(f, 63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_sound_tester.md
# i2s_sound_tester

Self-contained I2S test-tone source for bring-up of the audio DAC path. It derives master, bit and word clocks from a single 12.288 MHz input clock. It serialises a fixed 1 kHz square-wave test tone into standard Philips I2S frames, and also drives analyzer probe copies and status LEDs. It sits at the top of the board-level test build, directly driving the DAC pins.

## Interface
Parameters:
- SAMPLE_HI, 16'sh2000: positive half-cycle sample value.
- SAMPLE_LO, 16'shE000: negative half-cycle sample value.
- HALF_PERIOD_SAMPLES, 24: samples per tone half-period; 24 gives 1 kHz at 48 kHz.
- LED_HALF_FRAMES, 24000: frames per heartbeat toggle (0.5 s).

Ports (clock and reset first):
- input_clk, in, 1: sole clock, 12.288 MHz (256·fs, fs = 48 kHz).
- reset, in, 1: asynchronous, active-high reset.
- serial_clk, out, 1: I2S bit clock, input_clk/4 = 3.072 MHz (64·fs).
- dac_mclk, out, 1: DAC master clock, equal to input_clk (combinational pass-through).
- word_select, out, 1: I2S LRCLK; 0 = left channel, 1 = right channel.
- sound_bit_out, out, 1: I2S serial data, MSB first.
- serial_clk_analyzer, out, 1: copy of serial_clk.
- input_clk_analyzer, out, 1: copy of input_clk.
- test_LED, out, 1: 1 Hz heartbeat.
- test_LED_R, test_LED_G, test_LED_B, out, 1 each: 3-bit heartbeat counter display.
- bit_counter, out, 6: current bit slot in the frame, 0..63.

## Operation
- A 2-bit divider `div` increments on every input_clk rising edge; serial_clk = div[1].
  - serial_clk is high for div ∈ {2,3}.
  - A serial_clk falling event (SCE) occurs on the clock edge where div wraps 3→0.
- On each SCE:
  - bit_counter advances by 1 modulo 64 (63→0).
  - word_select, sound_bit_out and the sample register update in the same edge, registered.
- word_select = bit_counter[5] of the new count: low for slots 0..31, high for slots 32..63.
- Data is delayed one bit relative to word_select, per the I2S standard:
  - Slot position p = (bit_counter − 1) mod 32.
  - sound_bit_out = sample[15−p] for p < 16; otherwise 0.
  - MSB of left appears at slot 1; MSB of right appears at slot 33.
  - Slots 0 and 32 carry padding 0.
- Sample register:
  - Loaded when bit_counter becomes 0 (frame start).
  - Left and right channels carry the identical 16-bit two's-complement sample.
- Tone generation:
  - sample_idx counts frames modulo 2·HALF_PERIOD_SAMPLES (0..47).
  - Sample is SAMPLE_HI for idx 0..23 and SAMPLE_LO for idx 24..47.
- Heartbeat:
  - A frame counter toggles test_LED every LED_HALF_FRAMES frames.
  - Each rising toggle of test_LED increments a 3-bit counter mapped to {R,G,B} = {bit2,bit1,bit0}.
- While reset is high, all registers are held at their reset values:
  - div, bit_counter, sample_idx, frame counter and LED counter = 0.
  - serial_clk, word_select, sound_bit_out = 0.
  - All LEDs = 0.
  - Sample register = SAMPLE_HI.
- dac_mclk and input_clk_analyzer follow input_clk even during reset.

## Timing
- serial_clk period is 4 input_clk cycles with 50 % duty; the first rising edge comes 2 clocks after reset deassertion.
- All I2S outputs change only on SCE, i.e. on the serial_clk falling edge. The DAC samples them on the serial_clk rising edge, so data is stable for 2 input_clk cycles on either side.
- Frame length is 64 serial_clk = 256 input_clk cycles = 1/48 kHz.
- word_select transitions occur at slot 0 and slot 32, one bit before the corresponding MSB.
- Latency from frame start to the left MSB on sound_bit_out is 1 serial_clk.
- First frame after reset:
  - Slot 0 is the reset state.
  - The first SCE moves to slot 1 and outputs the MSB of SAMPLE_HI.
- Reset asserted mid-frame: all outputs clear asynchronously. Operation restarts at slot 0, sample_idx 0; no partial-frame resumption.

## Test plan
- Reset: hold reset=1 → serial_clk, word_select, sound_bit_out, bit_counter, LEDs all 0. dac_mclk toggles with input_clk throughout.
- Clocking: after reset release → serial_clk period 40 ns at a 10 ns input_clk, and bit_counter increments once per serial_clk falling edge, wrapping 63→0.
- Framing: across one frame → word_select=0 for bit_counter 0..31 and 1 for 32..63, with exactly 32 low and 32 high serial_clk cycles.
- Data, positive half-cycle: in the first full frame, sampled at serial_clk rising edges:
  - bit_counter 1..16 carries 0010_0000_0000_0000.
  - bit_counter 17..32 carries 0.
  - bit_counter 33..48 carries the same pattern.
  - bit_counter 49..63 and 0 carry 0.
- Tone: frames 0..23 carry 0x2000, frames 24..47 carry 0xE000 (1110_0000_0000_0000), and frame 48 returns to 0x2000.
- Mid-frame reset: assert reset for 3 cycles while bit_counter=40 → outputs clear immediately, and the next frame starts at slot 0 with sample 0x2000.
